// File: rtl/bin2bcd_pkg.sv
// Shared types and constant helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int unsigned BCD_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StFin
    } state_e;

    // 10^n-1; growth stops once past 32 bits, which keeps the 64-bit value exact
    // for any comparison against an operand of up to 32 bits.
    function automatic logic [63:0] pow10_m1(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            if (p < 64'h1_0000_0000) begin
                p = p * 64'd10;
            end
        end
        return p - 64'd1;
    endfunction

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more before the shift.
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [BCD_W-1:0] fixed
);

    always_comb begin
        fixed = (digit >= BCD_W'(5)) ? digit + BCD_W'(3) : digit;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter (one operand bit per clock) with start/busy/done
// handshake, overflow saturation and a leading-zero mask for display blanking.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      START,
    input  logic [BIN_W-1:0]          BIN,
    output logic                      BUSY,
    output logic                      DONE,
    output logic [BCD_W*DIGITS-1:0]   BCD,
    output logic                      OVF,
    output logic [DIGITS-1:0]         LZ_MASK
);

    localparam int unsigned ACC_W = BCD_W * DIGITS;
    localparam int unsigned CNT_W = clog2(BIN_W + 1);
    localparam logic [63:0] MAXV = pow10_m1(DIGITS);
    localparam logic [DIGITS-1:0] LZ_RST = ~DIGITS'(1);

    state_e state_q, state_d;

    logic [BIN_W-1:0]  sr_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_adj;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_pend_q;
    logic [ACC_W-1:0]  bcd_q;
    logic              ovf_q;
    logic [DIGITS-1:0] lz_q;
    logic [ACC_W-1:0]  res_bcd;
    logic [DIGITS-1:0] res_lz;
    logic [63:0]       bin_ext;
    logic              accept;
    logic              last;

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .digit (acc_q[BCD_W*i +: BCD_W]),
            .fixed (acc_adj[BCD_W*i +: BCD_W])
        );
    end

    assign bin_ext = 64'(BIN);
    assign accept  = START && (state_q != StShift);
    // Counter reaches BIN_W after the last shift; that extra cycle commits the result.
    assign last    = (cnt_q == CNT_W'(BIN_W));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (START) state_d = StShift;
            StShift: if (last)  state_d = StFin;
            StFin:   state_d = START ? StShift : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        BUSY    = (state_q == StShift);
        DONE    = (state_q == StFin);
        BCD     = bcd_q;
        OVF     = ovf_q;
        LZ_MASK = lz_q;
    end

    always_comb begin
        logic run;
        res_bcd = acc_q;
        if (ovf_pend_q) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                res_bcd[BCD_W*i +: BCD_W] = BCD_W'(9);
            end
        end
        res_lz = '0;
        run    = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            run       = run && (res_bcd[BCD_W*i +: BCD_W] == '0);
            res_lz[i] = run;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sr_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            lz_q       <= LZ_RST;
        end else begin
            if (accept) begin
                sr_q       <= BIN;
                acc_q      <= '0;
                cnt_q      <= '0;
                ovf_pend_q <= (bin_ext > MAXV);
            end else if (state_q == StShift && !last) begin
                // Carries out of the top digit are dropped; saturation covers those cases.
                {acc_q, sr_q} <= {acc_adj, sr_q} << 1;
                cnt_q         <= cnt_q + CNT_W'(1);
            end
            if (state_q == StShift && last) begin
                bcd_q <= res_bcd;
                ovf_q <= ovf_pend_q;
                lz_q  <= res_lz;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench: three converter configurations against an arithmetic reference.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // 16-bit, 5 digits
    logic        a_start = 1'b0;
    logic [15:0] a_bin = '0;
    logic        a_busy, a_done, a_ovf;
    logic [19:0] a_bcd;
    logic [4:0]  a_lz;
    // 16-bit, 4 digits (overflow possible)
    logic        b_start = 1'b0;
    logic [15:0] b_bin = '0;
    logic        b_busy, b_done, b_ovf;
    logic [15:0] b_bcd;
    logic [3:0]  b_lz;
    // 7-bit, 2 digits
    logic        c_start = 1'b0;
    logic [6:0]  c_bin = '0;
    logic        c_busy, c_done, c_ovf;
    logic [7:0]  c_bcd;
    logic [1:0]  c_lz;

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_dut_a (
        .CLK(clk), .RST(rst), .START(a_start), .BIN(a_bin), .BUSY(a_busy),
        .DONE(a_done), .BCD(a_bcd), .OVF(a_ovf), .LZ_MASK(a_lz)
    );
    bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) u_dut_b (
        .CLK(clk), .RST(rst), .START(b_start), .BIN(b_bin), .BUSY(b_busy),
        .DONE(b_done), .BCD(b_bcd), .OVF(b_ovf), .LZ_MASK(b_lz)
    );
    bin2bcd_seq #(.BIN_W(7), .DIGITS(2)) u_dut_c (
        .CLK(clk), .RST(rst), .START(c_start), .BIN(c_bin), .BUSY(c_busy),
        .DONE(c_done), .BCD(c_bcd), .OVF(c_ovf), .LZ_MASK(c_lz)
    );

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
        logic [4:0]  lz;
        logic        ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal digits by repeated division; overflow saturates to nines.
    function automatic void ref_conv(input longint unsigned v, input int digits,
                                     output logic [63:0] bcd, output logic [63:0] lz,
                                     output logic ovf);
        longint unsigned maxv = 1;
        longint unsigned t = v;
        longint unsigned p = 1;
        for (int i = 0; i < digits; i++) maxv = maxv * 10;
        maxv = maxv - 1;
        bcd = '0;
        lz  = '0;
        ovf = (v > maxv);
        for (int i = 0; i < digits; i++) begin
            bcd[4*i +: 4] = ovf ? 4'd9 : 4'(t % 10);
            t = t / 10;
        end
        for (int i = 1; i < digits; i++) begin
            p = p * 10;
            lz[i] = !ovf && ((v / p) == 0);
        end
    endfunction

    task automatic conv_a(input logic [15:0] v, output int lat);
        @(negedge clk); a_bin = v; a_start = 1'b1;
        @(posedge clk); #1; a_start = 1'b0;
        lat = 0;
        while (!a_done && lat < 40) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic conv_b(input logic [15:0] v, output int lat);
        @(negedge clk); b_bin = v; b_start = 1'b1;
        @(posedge clk); #1; b_start = 1'b0;
        lat = 0;
        while (!b_done && lat < 40) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic conv_c(input logic [6:0] v, output int lat);
        @(negedge clk); c_bin = v; c_start = 1'b1;
        @(posedge clk); #1; c_start = 1'b0;
        lat = 0;
        while (!c_done && lat < 40) begin @(posedge clk); #1; lat++; end
    endtask

    initial begin
        vec_t vecs[7];
        logic [63:0] e_bcd, e_lz;
        logic e_ovf;
        logic [15:0] r;
        int lat;
        int done_seen;

        vecs[0] = '{bin: 16'd12345, bcd: 20'h12345, lz: 5'b00000, ovf: 1'b0};
        vecs[1] = '{bin: 16'd0,     bcd: 20'h00000, lz: 5'b11110, ovf: 1'b0};
        vecs[2] = '{bin: 16'd907,   bcd: 20'h00907, lz: 5'b11000, ovf: 1'b0};
        vecs[3] = '{bin: 16'd65535, bcd: 20'h65535, lz: 5'b00000, ovf: 1'b0};
        vecs[4] = '{bin: 16'd9,     bcd: 20'h00009, lz: 5'b11110, ovf: 1'b0};
        vecs[5] = '{bin: 16'd10,    bcd: 20'h00010, lz: 5'b11100, ovf: 1'b0};
        vecs[6] = '{bin: 16'd1000,  bcd: 20'h01000, lz: 5'b10000, ovf: 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_bcd", a_bcd, 0);
        check("rst_lz", a_lz, 5'b11110);
        check("rst_ovf", a_ovf, 0);
        check("rst_b_lz", b_lz, 4'b1110);
        check("rst_c_lz", c_lz, 2'b10);

        foreach (vecs[i]) begin
            conv_a(vecs[i].bin, lat);
            check($sformatf("tbl_lat[%0d]", i), lat, 17);
            check($sformatf("tbl_bcd[%0d]", i), a_bcd, vecs[i].bcd);
            check($sformatf("tbl_lz[%0d]", i), a_lz, vecs[i].lz);
            check($sformatf("tbl_ovf[%0d]", i), a_ovf, vecs[i].ovf);
            check($sformatf("tbl_busy[%0d]", i), a_busy, 0);
        end

        for (int i = 0; i < 30; i++) begin
            r = 16'($urandom_range(0, 65535));
            if (i % 3 == 0) r = 16'($urandom_range(0, 120));
            conv_a(r, lat);
            ref_conv(r, 5, e_bcd, e_lz, e_ovf);
            check($sformatf("rnd_a_lat %0d", r), lat, 17);
            check($sformatf("rnd_a_bcd %0d", r), a_bcd, e_bcd);
            check($sformatf("rnd_a_lz %0d", r), a_lz, e_lz);
        end

        // START during SHIFT ignored; then back-to-back START in the DONE cycle.
        conv_a(16'd77, lat);
        @(negedge clk); a_bin = 16'd12345; a_start = 1'b1;
        @(posedge clk); #1; a_start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); a_bin = 16'd555; a_start = 1'b1;
        @(posedge clk); #1; a_start = 1'b0; a_bin = 16'hFFFF;
        check("hold_bcd_mid_shift", a_bcd, 20'h00077);
        lat = 6;
        while (!a_done && lat < 40) begin @(posedge clk); #1; lat++; end
        check("ign_lat", lat, 17);
        check("ign_bcd", a_bcd, 20'h12345);
        a_bin = 16'd4321; a_start = 1'b1;
        @(posedge clk); #1; a_start = 1'b0;
        check("b2b_no_double_done", a_done, 0);
        check("b2b_busy", a_busy, 1);
        lat = 0;
        while (!a_done && lat < 40) begin @(posedge clk); #1; lat++; end
        check("b2b_lat", lat, 17);
        check("b2b_bcd", a_bcd, 20'h04321);
        check("b2b_lz", a_lz, 5'b10000);

        // Reset mid-conversion discards the result.
        @(negedge clk); a_bin = 16'd12345; a_start = 1'b1;
        @(posedge clk); #1; a_start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check("mrst_busy", a_busy, 0);
        check("mrst_done", a_done, 0);
        check("mrst_bcd", a_bcd, 0);
        check("mrst_lz", a_lz, 5'b11110);
        check("mrst_ovf", a_ovf, 0);
        done_seen = 0;
        repeat (20) begin @(posedge clk); #1; if (a_done) done_seen++; end
        check("mrst_no_done", done_seen, 0);
        conv_a(16'd907, lat);
        check("mrst_907_lat", lat, 17);
        check("mrst_907_bcd", a_bcd, 20'h00907);
        check("mrst_907_lz", a_lz, 5'b11000);

        // Four digits: saturation.
        conv_b(16'd65535, lat);
        check("b_ovf_lat", lat, 17);
        check("b_ovf", b_ovf, 1);
        check("b_ovf_bcd", b_bcd, 16'h9999);
        check("b_ovf_lz", b_lz, 0);
        conv_b(16'd0, lat);
        check("b_zero_ovf", b_ovf, 0);
        check("b_zero_bcd", b_bcd, 0);
        check("b_zero_lz", b_lz, 4'b1110);
        for (int i = 0; i < 20; i++) begin
            r = 16'($urandom_range(0, 65535));
            if (i % 2 == 0) r = 16'($urandom_range(9990, 10010));
            conv_b(r, lat);
            ref_conv(r, 4, e_bcd, e_lz, e_ovf);
            check($sformatf("rnd_b_bcd %0d", r), b_bcd, e_bcd);
            check($sformatf("rnd_b_lz %0d", r), b_lz, e_lz);
            check($sformatf("rnd_b_ovf %0d", r), b_ovf, e_ovf);
        end

        // Seven-bit, two-digit sweep.
        for (int v = 0; v < 128; v++) begin
            conv_c(7'(v), lat);
            check($sformatf("c_lat %0d", v), lat, 8);
            if (v < 100) begin
                check($sformatf("c_bcd %0d", v), c_bcd, 64'((v / 10) * 16 + (v % 10)));
                check($sformatf("c_lz %0d", v), c_lz, (v < 10) ? 2'b10 : 2'b00);
                check($sformatf("c_ovf %0d", v), c_ovf, 0);
            end else begin
                check($sformatf("c_bcd %0d", v), c_bcd, 8'h99);
                check($sformatf("c_lz %0d", v), c_lz, 0);
                check($sformatf("c_ovf %0d", v), c_ovf, 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
